// File: rtl/bricks_pkg.sv
// rtl/bricks_pkg.sv - shared game state encodings and counter widths for the brick-breaker datapath
package bricks_pkg;

    localparam int LIVES_W = 3;
    localparam int LEVEL_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_LOST  = 3'd4,
        ST_LVLUP = 3'd5,
        ST_OVER  = 3'd6,
        ST_WIN   = 3'd7
    } game_state_t;

endpackage

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - keypad/playfield inputs and game-flow outputs of the sequencer
interface game_sequencer_if;
    import bricks_pkg::*;

    logic               start_key;
    logic               pause_key;
    logic               ball_lost;
    logic               bricks_empty;
    logic               step;
    logic               serve;
    logic               load_bricks;
    logic [LIVES_W-1:0] lives;
    logic [LEVEL_W-1:0] level;
    logic [2:0]         state;
    logic               playing;
    logic               game_over;
    logic               game_win;

    // Keypad decode / playfield side: drives keys and status, consumes strobes
    modport master (
        output start_key, pause_key, ball_lost, bricks_empty,
        input  step, serve, load_bricks, lives, level, state, playing, game_over, game_win
    );

    // Sequencer side
    modport slave (
        input  start_key, pause_key, ball_lost, bricks_empty,
        output step, serve, load_bricks, lives, level, state, playing, game_over, game_win
    );

endinterface

// File: rtl/game_sequencer_step_timer.sv
// rtl/game_sequencer_step_timer.sv - loadable-period divider producing a one-cycle tick
module step_timer #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] period,
    input  logic         run,
    input  logic         hold,
    input  logic         clear,
    output logic         tick
);

    logic [W-1:0] cnt;
    logic         at_end;

    assign at_end = (cnt == period - W'(1));
    // Tick only fires while actually counting, so a held or cleared timer is silent
    assign tick   = run & ~hold & ~clear & at_end;

    // Count up to period-1 and wrap; clear wins over hold, hold wins over run
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !hold) begin
            if (at_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - brick-breaker game-flow FSM with step timing, lives and level
module game_sequencer
    import bricks_pkg::*;
#(
    parameter int TICK_DIV    = 25_000_000,
    parameter int LEVEL_STEP  = 5_000_000,
    parameter int MAX_LEVEL   = 3,
    parameter int LIVES_INIT  = 3,
    parameter int SERVE_STEPS = 4
) (
    input  logic              clock,
    input  logic              reset,
    game_sequencer_if.slave   bus
);

    game_state_t        state;
    logic [LIVES_W-1:0] lives;
    logic [LEVEL_W-1:0] level;
    logic [7:0]         serve_cnt;
    logic               serve_r;
    logic               load_r;
    logic               start_q;
    logic               pause_q;
    logic               start_req;
    logic               pause_req;
    logic [31:0]        period;
    logic               tick;
    logic               run;
    logic               hold;
    logic               clear;

    // Higher levels shorten the step period
    assign period = 32'(TICK_DIV) - 32'(level) * 32'(LEVEL_STEP);
    assign run    = (state == ST_SERVE) || (state == ST_PLAY);
    assign hold   = (state == ST_PAUSE);
    assign clear  = !(run || hold);

    step_timer #(.W(32)) u_step_timer (
        .clock  (clock),
        .reset  (reset),
        .period (period),
        .run    (run),
        .hold   (hold),
        .clear  (clear),
        .tick   (tick)
    );

    // Registered rising-edge detect: a held key yields exactly one request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            start_req <= 1'b0;
            pause_req <= 1'b0;
        end else begin
            start_q   <= bus.start_key;
            pause_q   <= bus.pause_key;
            start_req <= bus.start_key & ~start_q;
            pause_req <= bus.pause_key & ~pause_q;
        end
    end

    // Game-flow FSM; strobes are registered so they land on the first SERVE cycle, never in PLAY
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            lives     <= '0;
            level     <= '0;
            serve_cnt <= '0;
            serve_r   <= 1'b0;
            load_r    <= 1'b0;
        end else begin
            serve_r <= 1'b0;
            load_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state     <= ST_SERVE;
                        lives     <= LIVES_W'(LIVES_INIT);
                        level     <= '0;
                        serve_cnt <= '0;
                        serve_r   <= 1'b1;
                        load_r    <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (start_req) begin
                        state <= ST_PLAY;
                    end else if (tick) begin
                        if (serve_cnt == 8'(SERVE_STEPS - 1)) begin
                            state <= ST_PLAY;
                        end else begin
                            serve_cnt <= serve_cnt + 8'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (bus.ball_lost) begin
                        state <= ST_LOST;
                    end else if (bus.bricks_empty) begin
                        state <= ST_LVLUP;
                    end else if (pause_req) begin
                        state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (pause_req) begin
                        state <= ST_PLAY;
                    end
                end
                ST_LOST: begin
                    if (lives != '0) begin
                        lives <= lives - LIVES_W'(1);
                    end
                    if (lives <= LIVES_W'(1)) begin
                        state <= ST_OVER;
                    end else begin
                        state     <= ST_SERVE;
                        serve_cnt <= '0;
                        serve_r   <= 1'b1;
                    end
                end
                ST_LVLUP: begin
                    if (level == LEVEL_W'(MAX_LEVEL)) begin
                        state <= ST_WIN;
                    end else begin
                        state     <= ST_SERVE;
                        level     <= level + LEVEL_W'(1);
                        serve_cnt <= '0;
                        serve_r   <= 1'b1;
                        load_r    <= 1'b1;
                    end
                end
                ST_OVER, ST_WIN: begin
                    if (start_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.step        = tick & (state == ST_PLAY);
    assign bus.serve       = serve_r;
    assign bus.load_bricks = load_r;
    assign bus.lives       = lives;
    assign bus.level       = level;
    assign bus.state       = state;
    assign bus.playing     = (state == ST_PLAY);
    assign bus.game_over   = (state == ST_OVER);
    assign bus.game_win    = (state == ST_WIN);

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed table and sequence checks for game_sequencer
module tb_game_sequencer;
    import bricks_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    game_sequencer_if bus();

    game_sequencer #(
        .TICK_DIV    (10),
        .LEVEL_STEP  (2),
        .MAX_LEVEL   (3),
        .LIVES_INIT  (3),
        .SERVE_STEPS (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic sk;
        logic pk;
        logic bl;
        logic be;
        int   n;
        int   st;
        int   lv;
        int   lev;
        int   sv;
        int   ld;
        int   stp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clock);
        #1;
    endtask

    task automatic press_start();
        bus.start_key = 1'b1;
        tick1();
        bus.start_key = 1'b0;
        tick1();
    endtask

    task automatic press_pause();
        bus.pause_key = 1'b1;
        tick1();
        bus.pause_key = 1'b0;
        tick1();
    endtask

    task automatic wait_state(input int target, input int budget);
        int n;
        n = 0;
        while (int'(bus.state) != target && n < budget) begin
            tick1();
            n++;
        end
        chk("wait_state", int'(bus.state), target);
    endtask

    // Cycles from a sampled step to the next step
    task automatic step_gap(output int gap);
        int n;
        n = 0;
        while (!bus.step && n < 40) begin
            tick1();
            n++;
        end
        gap = 0;
        do begin
            tick1();
            gap++;
        end while (!bus.step && gap < 40);
    endtask

    task automatic lose_ball(input int exp_lives, input int exp_state);
        bus.ball_lost = 1'b1;
        tick1();
        bus.ball_lost = 1'b0;
        chk("lost_state", int'(bus.state), int'(ST_LOST));
        tick1();
        chk("lost_lives", int'(bus.lives), exp_lives);
        chk("lost_next", int'(bus.state), exp_state);
    endtask

    task automatic level_up(input int cur_level);
        bus.bricks_empty = 1'b1;
        tick1();
        bus.bricks_empty = 1'b0;
        chk("lvlup_state", int'(bus.state), int'(ST_LVLUP));
        tick1();
        if (cur_level == 3) begin
            chk("win_state", int'(bus.state), int'(ST_WIN));
            chk("win_flag", int'(bus.game_win), 1);
            chk("win_level_hold", int'(bus.level), 3);
        end else begin
            chk("lvl_state", int'(bus.state), int'(ST_SERVE));
            chk("lvl_level", int'(bus.level), cur_level + 1);
            chk("lvl_load", int'(bus.load_bricks), 1);
            chk("lvl_serve", int'(bus.serve), 1);
            chk("lvl_nostep", int'(bus.step), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int gap;
        int steps;
        int loads;
        checks   = 0;
        failures = 0;
        bus.start_key    = 1'b0;
        bus.pause_key    = 1'b0;
        bus.ball_lost    = 1'b0;
        bus.bricks_empty = 1'b0;
        reset = 1'b0;

        // Test 1 then test 2: start, serve timing, step cadence, simultaneous lost+empty
        tbl[0]  = '{0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0,  1, 1, 3, 0, 1, 1, 0};
        tbl[3]  = '{0, 0, 0, 0,  1, 1, 3, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 18, 1, 3, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0,  1, 2, 3, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0,  8, 2, 3, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0,  1, 2, 3, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0,  1, 2, 3, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0,  9, 2, 3, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 1, 1,  1, 4, 3, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0,  1, 1, 2, 0, 1, 0, 0};

        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", int'(bus.state), 0);
        chk("reset_lives", int'(bus.lives), 0);
        chk("reset_strobes", int'({bus.step, bus.serve, bus.load_bricks}), 0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus.start_key    = tbl[i].sk;
            bus.pause_key    = tbl[i].pk;
            bus.ball_lost    = tbl[i].bl;
            bus.bricks_empty = tbl[i].be;
            repeat (tbl[i].n) @(posedge clock);
            #1;
            chk($sformatf("vec%0d_state", i), int'(bus.state), tbl[i].st);
            chk($sformatf("vec%0d_lives", i), int'(bus.lives), tbl[i].lv);
            chk($sformatf("vec%0d_level", i), int'(bus.level), tbl[i].lev);
            chk($sformatf("vec%0d_serve", i), int'(bus.serve), tbl[i].sv);
            chk($sformatf("vec%0d_load", i), int'(bus.load_bricks), tbl[i].ld);
            chk($sformatf("vec%0d_step", i), int'(bus.step), tbl[i].stp);
        end
        bus.ball_lost    = 1'b0;
        bus.bricks_empty = 1'b0;

        // Test 4: level-ups shorten the period by 2 each level, clearing level 3 wins
        for (int lv = 0; lv <= 3; lv++) begin
            wait_state(int'(ST_PLAY), 60);
            step_gap(gap);
            chk($sformatf("period_lvl%0d", lv), gap, 10 - 2 * lv);
            level_up(lv);
        end

        // Game over/win: first start returns to IDLE, second starts a new game
        press_start();
        chk("win_to_idle", int'(bus.state), int'(ST_IDLE));
        press_start();
        chk("new_game_state", int'(bus.state), int'(ST_SERVE));
        chk("new_game_lives", int'(bus.lives), 3);
        chk("new_game_level", int'(bus.level), 0);

        // Test 3: three losses end the game with lives at zero and no more steps
        wait_state(int'(ST_PLAY), 60);
        lose_ball(2, int'(ST_SERVE));
        wait_state(int'(ST_PLAY), 60);
        lose_ball(1, int'(ST_SERVE));
        wait_state(int'(ST_PLAY), 60);
        lose_ball(0, int'(ST_OVER));
        chk("over_flag", int'(bus.game_over), 1);
        steps = 0;
        for (int c = 0; c < 40; c++) begin
            tick1();
            steps += int'(bus.step);
        end
        chk("over_no_step", steps, 0);
        chk("over_lives_hold", int'(bus.lives), 0);

        press_start();
        press_start();
        chk("game3_state", int'(bus.state), int'(ST_SERVE));

        // Test 5: pause with counter held at 4, ball_lost ignored, resume after 5 cycles
        wait_state(int'(ST_PLAY), 60);
        tick1();
        tick1();
        press_pause();
        chk("pause_state", int'(bus.state), int'(ST_PAUSE));
        bus.ball_lost = 1'b1;
        steps = 0;
        for (int c = 0; c < 20; c++) begin
            tick1();
            steps += int'(bus.step);
        end
        bus.ball_lost = 1'b0;
        chk("pause_no_step", steps, 0);
        chk("pause_hold_state", int'(bus.state), int'(ST_PAUSE));
        chk("pause_lives", int'(bus.lives), 3);
        press_pause();
        chk("resume_state", int'(bus.state), int'(ST_PLAY));
        gap = 0;
        while (!bus.step && gap < 20) begin
            tick1();
            gap++;
        end
        chk("resume_first_step", gap, 5);

        // Test 6: reach level 2 with one life, then reset mid-play
        lose_ball(2, int'(ST_SERVE));
        wait_state(int'(ST_PLAY), 60);
        lose_ball(1, int'(ST_SERVE));
        wait_state(int'(ST_PLAY), 60);
        level_up(0);
        wait_state(int'(ST_PLAY), 60);
        level_up(1);
        wait_state(int'(ST_PLAY), 60);
        chk("pre_reset_level", int'(bus.level), 2);
        chk("pre_reset_lives", int'(bus.lives), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_state", int'(bus.state), 0);
        chk("async_reset_lives", int'(bus.lives), 0);
        chk("async_reset_level", int'(bus.level), 0);
        chk("async_reset_outs", int'({bus.step, bus.serve, bus.load_bricks,
                                      bus.playing, bus.game_over, bus.game_win}), 0);
        bus.start_key = 1'b1;
        tick1();
        reset = 1'b1;
        tick1();
        tick1();
        chk("held_start_serve", int'(bus.state), int'(ST_SERVE));
        loads = 0;
        for (int c = 0; c < 10; c++) begin
            tick1();
            loads += int'(bus.load_bricks);
        end
        chk("held_start_one_req", int'(bus.state), int'(ST_SERVE));
        chk("held_start_no_reload", loads, 0);
        bus.start_key = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
